// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the multiply/divide unit: op codes and FSM states.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/muldiv_unit_div_iter.sv
// Restoring divider datapath on unsigned operands; one quotient bit per step.
// quot_next/rem_next expose the post-step values so the caller can register them on the final step.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quot_next,
  output logic [WIDTH-1:0] rem_next
);

  logic [WIDTH-1:0] quot_r, rem_r, div_r;
  logic [WIDTH:0]   shifted;
  logic             ge;

  // Partial remainder is always < divisor, so the difference fits in WIDTH bits.
  assign shifted   = {rem_r, quot_r[WIDTH-1]};
  assign ge        = shifted >= {1'b0, div_r};
  assign rem_next  = ge ? (shifted[WIDTH-1:0] - div_r) : shifted[WIDTH-1:0];
  assign quot_next = {quot_r[WIDTH-2:0], ge};

  always_ff @(posedge clk) begin
    if (!rst) begin
      quot_r <= '0;
      rem_r  <= '0;
      div_r  <= '0;
    end else if (load) begin
      quot_r <= dividend;
      rem_r  <= '0;
      div_r  <= divisor;
    end else if (step) begin
      quot_r <= quot_next;
      rem_r  <= rem_next;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU unit producing {HI,LO}; start/busy/done handshake with flush.
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  localparam int CW = $clog2(WIDTH + MUL_STAGES + 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               mul_sgn, neg_q, neg_r;
  logic               accept, sgn_div;
  logic [WIDTH-1:0]   a_abs, b_abs, quot_n, rem_n, quot_fix, rem_fix;
  logic [2*WIDTH-1:0] mul_a, mul_b, product;

  assign accept  = (state == S_IDLE || state == S_DONE) && start && !flush;
  assign sgn_div = (op == OP_DIV);
  assign a_abs   = (sgn_div && a[WIDTH-1]) ? -a : a;
  assign b_abs   = (sgn_div && b[WIDTH-1]) ? -b : b;

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && op[1]),
    .step     (state == S_DIV),
    .dividend (a_abs),
    .divisor  (b_abs),
    .quot_next(quot_n),
    .rem_next (rem_n)
  );

  // Extending to 2*WIDTH before multiplying gives the exact product for both signednesses.
  assign mul_a    = {{WIDTH{mul_sgn & a_q[WIDTH-1]}}, a_q};
  assign mul_b    = {{WIDTH{mul_sgn & b_q[WIDTH-1]}}, b_q};
  assign product  = mul_a * mul_b;
  assign quot_fix = neg_q ? -quot_n : quot_n;
  assign rem_fix  = neg_r ? -rem_n : rem_n;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mul_sgn     <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state       <= S_IDLE;
        busy        <= 1'b0;
        div_by_zero <= 1'b0;
      end else begin
        case (state)
          S_MUL: begin
            if (cnt == CW'(MUL_STAGES - 1)) begin
              state  <= S_DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= product;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_DIV: begin
            if (cnt == CW'(WIDTH - 1)) begin
              state  <= S_DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= {rem_fix, quot_fix};
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            if (start) begin
              a_q         <= a;
              b_q         <= b;
              mul_sgn     <= (op == OP_MULT);
              neg_q       <= sgn_div & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r       <= sgn_div & a[WIDTH-1];
              cnt         <= '0;
              div_by_zero <= 1'b0;
              if (op[1] && b == '0) begin
                state       <= S_DONE;
                busy        <= 1'b0;
                done        <= 1'b1;
                result      <= {a, {WIDTH{1'b1}}};
                div_by_zero <= 1'b1;
              end else begin
                state <= op[1] ? S_DIV : S_MUL;
                busy  <= 1'b1;
              end
            end else begin
              state <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, hand-written handshake sequences, random ops vs model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           flush = 1'b0;
  logic [1:0]     op = 2'b00;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           busy, done, div_by_zero;
  logic [2*W-1:0] result;

  int tests = 0;
  int fails = 0;

  muldiv_unit #(.WIDTH(W), .MUL_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        dbz;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, q, r;
    logic [63:0] ux, uy, qv, rv;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      2'b00: return sx * sy;
      2'b01: return ux * uy;
      default: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        if (o == 2'b10) begin
          q = sx / sy;
          r = sx % sy;
          qv = q;
          rv = r;
        end else begin
          qv = ux / uy;
          rv = ux % uy;
        end
        return {rv[31:0], qv[31:0]};
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] y);
    if (!o[1]) return 3;
    return (y == 32'd0) ? 1 : W + 1;
  endfunction

  // Waits (at negedges) for done; cyc is the cycle index of the current negedge.
  task automatic wait_done(input int cyc, output int lat);
    lat = -1;
    for (int c = cyc; c <= 100; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic [63:0] res, output logic dbz, output logic busy1);
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 2'($urandom_range(0, 3));
    busy1 = busy;
    wait_done(1, lat);
    res = result;
    dbz = div_by_zero;
  endtask

  vec_t        vecs[9];
  int          lat;
  logic [63:0] res;
  logic        dbz, busy1, saw_done;
  logic [1:0]  ro;
  logic [31:0] ra, rb;

  initial begin
    vecs[0] = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFF_FFFFFFFA, 1'b0, 3};
    vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0, 3};
    vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b0, 33};
    vecs[3] = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC, 1'b0, 33};
    vecs[4] = '{2'b11, 32'h12345678, 32'h00000000, 64'h12345678_FFFFFFFF, 1'b1, 1};
    vecs[5] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 33};
    vecs[6] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0, 33};
    vecs[7] = '{2'b00, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000, 1'b0, 3};
    vecs[8] = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 64'hFFFFFFF9_FFFFFFFF, 1'b1, 1};

    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, res, dbz, busy1);
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d_result", i), res, vecs[i].res);
      check($sformatf("vec%0d_dbz", i), 64'(dbz), 64'(vecs[i].dbz));
      check($sformatf("vec%0d_busy1", i), 64'(busy1), 64'(vecs[i].lat != 1));
    end

    // Flag persists in IDLE, clears on the next accept.
    run_op(2'b11, 32'h55, 32'h0, lat, res, dbz, busy1);
    @(negedge clk);
    check("dbz_hold_idle", 64'(div_by_zero), 64'd1);
    start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    check("dbz_clear_accept", 64'(div_by_zero), 64'd0);
    wait_done(1, lat);
    check("dbz_clear_result", result, 64'd6);

    // Back-to-back: new start in DONE.
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("b2b_done3", 64'(done), 64'd1);
    check("b2b_res3", result, 64'd15);
    start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    check("b2b_done4", 64'(done), 64'd0);
    check("b2b_busy4", 64'(busy), 64'd1);
    @(negedge clk);
    check("b2b_done5", 64'(done), 64'd0);
    @(negedge clk);
    check("b2b_done6", 64'(done), 64'd1);
    check("b2b_res6", result, 64'd4);

    // Flush together with start at cycle 10 of a divide.
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    @(negedge clk);
    flush = 1'b1; start = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    check("flush_busy11", 64'(busy), 64'd0);
    check("flush_done11", 64'(done), 64'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("flush_quiet", 64'(saw_done), 64'd0);
    check("flush_result", result, 64'd4);

    // Start while busy is ignored.
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(4, lat);
    check("busy_start_lat", 64'(lat), 64'd33);
    check("busy_start_res", result, {32'd2, 32'd14});
    saw_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("busy_start_nodone", 64'(saw_done), 64'd0);

    // Reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("rst_nodone", 64'(saw_done), 64'd0);

    // Random operations against the model.
    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        3: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      run_op(ro, ra, rb, lat, res, dbz, busy1);
      check($sformatf("rnd%0d_lat op%0d %h/%h", i, ro, ra, rb), 64'(lat), 64'(ref_lat(ro, rb)));
      check($sformatf("rnd%0d_res op%0d %h/%h", i, ro, ra, rb), res, ref_res(ro, ra, rb));
      check($sformatf("rnd%0d_dbz", i), 64'(dbz), 64'(ro[1] && rb == 32'd0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
